// File: rtl/comp_sampler_pkg.sv
// Shared definitions for the comparator sampler: filter FSM encoding,
// event-type constants and a small level-decode helper.
package comp_sampler_pkg;

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        PEND_HIGH = 2'd1,
        ST_HIGH   = 2'd2,
        PEND_LOW  = 2'd3
    } state_t;

    localparam logic EVT_RISE = 1'b1;
    localparam logic EVT_FALL = 1'b0;

    // The filtered level is high while settled high or while a fall is
    // still being qualified.
    function automatic logic state_is_high(state_t s);
        return (s == ST_HIGH) || (s == PEND_LOW);
    endfunction

endpackage

// File: rtl/comp_sampler_if.sv
// Event output channel of the comparator sampler: valid/ready handshake
// carrying edge type and timestamp, plus the sticky dropped-event flag.
interface comp_sampler_if #(
    parameter int CNT_W = 16
) ();

    logic             evt_valid;
    logic             evt_ready;
    logic             evt_type;
    logic [CNT_W-1:0] evt_time;
    logic             evt_ovf;

    modport master (
        output evt_valid,
        output evt_type,
        output evt_time,
        output evt_ovf,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_type,
        input  evt_time,
        input  evt_ovf,
        output evt_ready
    );

endinterface

// File: rtl/comp_sync.sv
// Multi-flop synchroniser bringing the asynchronous comparator output
// into the clock domain. Only the last stage is used downstream.
module comp_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic resetb,
    input  logic async_in,
    output logic samp
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw comparator level through the synchroniser chain.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

    assign samp = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/comp_sampler.sv
// Comparator sampler: synchronises comp_in, glitch-filters it with a
// programmable stable-cycle count, reports accepted edges as pulses,
// saturating counts and a one-deep event register with overflow flag.
// Optional build macro COMP_SAMPLER_TIMESTAMP_EN adds a free-running
// timer whose value is captured into evt_time; otherwise evt_time is 0.
// The evt interface instance must be built with the same CNT_W.
module comp_sampler
    import comp_sampler_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 8,
    parameter int CNT_W       = 16
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              comp_in,
    input  logic              enable,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              clear,
    output logic              level_o,
    output logic              rise_o,
    output logic              fall_o,
    output logic [CNT_W-1:0]  rise_cnt,
    output logic [CNT_W-1:0]  fall_cnt,
    comp_sampler_if.master    evt
);

    logic              samp;
    state_t            state, state_nxt;
    logic [FILT_W-1:0] filt_cnt, filt_cnt_nxt;
    logic [FILT_W-1:0] filt_lim, filt_lim_nxt;
    logic              accept_rise, accept_fall;
    logic [CNT_W-1:0]  stamp;

    comp_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock    (clock),
        .resetb   (resetb),
        .async_in (comp_in),
        .samp     (samp)
    );

`ifdef COMP_SAMPLER_TIMESTAMP_EN
    logic [CNT_W-1:0] timer;

    // Free-running wrapping timer, only reset clears it.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            timer <= '0;
        end else begin
            timer <= timer + CNT_W'(1);
        end
    end

    assign stamp = timer;
`else
    assign stamp = '0;
`endif

    // Filter FSM next state; the limit is latched on pending entry so later
    // filt_len changes do not disturb a qualification already in progress.
    always_comb begin
        state_nxt    = state;
        filt_cnt_nxt = filt_cnt;
        filt_lim_nxt = filt_lim;
        accept_rise  = 1'b0;
        accept_fall  = 1'b0;
        if (!enable) begin
            state_nxt    = samp ? ST_HIGH : ST_LOW;
            filt_cnt_nxt = '0;
        end else begin
            case (state)
                ST_LOW: begin
                    if (samp) begin
                        state_nxt    = PEND_HIGH;
                        filt_cnt_nxt = '0;
                        filt_lim_nxt = filt_len;
                    end
                end
                PEND_HIGH: begin
                    if (!samp) begin
                        state_nxt = ST_LOW;
                    end else if (filt_cnt == filt_lim) begin
                        state_nxt   = ST_HIGH;
                        accept_rise = 1'b1;
                    end else begin
                        filt_cnt_nxt = filt_cnt + FILT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (!samp) begin
                        state_nxt    = PEND_LOW;
                        filt_cnt_nxt = '0;
                        filt_lim_nxt = filt_len;
                    end
                end
                PEND_LOW: begin
                    if (samp) begin
                        state_nxt = ST_HIGH;
                    end else if (filt_cnt == filt_lim) begin
                        state_nxt   = ST_LOW;
                        accept_fall = 1'b1;
                    end else begin
                        filt_cnt_nxt = filt_cnt + FILT_W'(1);
                    end
                end
                default: state_nxt = ST_LOW;
            endcase
        end
    end

    // FSM registers and the edge pulses, registered on the same edge as the level.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state    <= ST_LOW;
            filt_cnt <= '0;
            filt_lim <= '0;
            rise_o   <= 1'b0;
            fall_o   <= 1'b0;
        end else begin
            state    <= state_nxt;
            filt_cnt <= filt_cnt_nxt;
            filt_lim <= filt_lim_nxt;
            rise_o   <= accept_rise;
            fall_o   <= accept_fall;
        end
    end

    assign level_o = state_is_high(state);

    // Saturating edge counters; clear wins over a same-cycle edge.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rise_cnt <= '0;
            fall_cnt <= '0;
        end else if (clear) begin
            rise_cnt <= '0;
            fall_cnt <= '0;
        end else begin
            if (accept_rise && (rise_cnt != '1)) begin
                rise_cnt <= rise_cnt + CNT_W'(1);
            end
            if (accept_fall && (fall_cnt != '1)) begin
                fall_cnt <= fall_cnt + CNT_W'(1);
            end
        end
    end

    // One-deep event register: load when free or emptied this cycle, else flag a drop.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            evt.evt_valid <= 1'b0;
            evt.evt_type  <= 1'b0;
            evt.evt_time  <= '0;
            evt.evt_ovf   <= 1'b0;
        end else if (clear) begin
            evt.evt_valid <= 1'b0;
            evt.evt_ovf   <= 1'b0;
        end else if (accept_rise || accept_fall) begin
            if (!evt.evt_valid || evt.evt_ready) begin
                evt.evt_valid <= 1'b1;
                evt.evt_type  <= accept_rise ? EVT_RISE : EVT_FALL;
                evt.evt_time  <= stamp;
            end else begin
                evt.evt_ovf   <= 1'b1;
            end
        end else if (evt.evt_valid && evt.evt_ready) begin
            evt.evt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_comp_sampler.sv
// Directed self-checking bench for comp_sampler. A second instance with
// CNT_W=4 shares the stimulus to exercise counter saturation.
module tb_comp_sampler;

    logic        clock;
    logic        resetb;
    logic        comp_in;
    logic        enable;
    logic [7:0]  filt_len;
    logic        clear;
    logic        level_o, rise_o, fall_o;
    logic [15:0] rise_cnt, fall_cnt;
    logic        level4, rise4, fall4;
    logic [3:0]  rise_cnt4, fall_cnt4;

    int          tests_run = 0;
    int          failures  = 0;
    logic        saw_rise;
    logic        saw_fall;
    logic [15:0] exp_time;

    comp_sampler_if #(.CNT_W(16)) evt_if ();
    comp_sampler_if #(.CNT_W(4))  evt4_if ();

    comp_sampler #(.SYNC_STAGES(2), .FILT_W(8), .CNT_W(16)) dut (
        .clock    (clock),
        .resetb   (resetb),
        .comp_in  (comp_in),
        .enable   (enable),
        .filt_len (filt_len),
        .clear    (clear),
        .level_o  (level_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .rise_cnt (rise_cnt),
        .fall_cnt (fall_cnt),
        .evt      (evt_if)
    );

    comp_sampler #(.SYNC_STAGES(2), .FILT_W(8), .CNT_W(4)) dut4 (
        .clock    (clock),
        .resetb   (resetb),
        .comp_in  (comp_in),
        .enable   (enable),
        .filt_len (filt_len),
        .clear    (clear),
        .level_o  (level4),
        .rise_o   (rise4),
        .fall_o   (fall4),
        .rise_cnt (rise_cnt4),
        .fall_cnt (fall_cnt4),
        .evt      (evt4_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef COMP_SAMPLER_TIMESTAMP_EN
    logic [15:0] tb_timer;
    // Reference clock-cycle count since reset release.
    always @(posedge clock or negedge resetb) begin
        if (!resetb) tb_timer <= '0;
        else         tb_timer <= tb_timer + 16'd1;
    end
`endif

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (rise_o) saw_rise = 1'b1;
        if (fall_o) saw_fall = 1'b1;
    endtask

    task automatic applyStimulus(input logic comp, input int cycles);
        comp_in = comp;
        repeat (cycles) tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetb = 1'b0; comp_in = 1'b0; enable = 1'b1; filt_len = 8'd3; clear = 1'b0;
        evt_if.evt_ready = 1'b0; evt4_if.evt_ready = 1'b1;
        saw_rise = 1'b0; saw_fall = 1'b0; exp_time = '0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_level",    32'(level_o),          32'd0);
        checkOutput("rst_rise_o",   32'(rise_o),           32'd0);
        checkOutput("rst_rise_cnt", 32'(rise_cnt),         32'd0);
        checkOutput("rst_fall_cnt", 32'(fall_cnt),         32'd0);
        checkOutput("rst_valid",    32'(evt_if.evt_valid), 32'd0);
        checkOutput("rst_ovf",      32'(evt_if.evt_ovf),   32'd0);
        checkOutput("rst_time",     32'(evt_if.evt_time),  32'd0);
        resetb = 1'b1;
        repeat (3) tick();

        // Rise with filt_len=3: accepted on the 7th edge after comp_in rises
        comp_in = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) checkOutput("rise_early_level", 32'(level_o), 32'd0);
            if (k == 7) begin
                checkOutput("rise_level",  32'(level_o), 32'd1);
                checkOutput("rise_pulse",  32'(rise_o),  32'd1);
`ifdef COMP_SAMPLER_TIMESTAMP_EN
                exp_time = tb_timer - 16'd1;
`endif
            end
        end
        tick();
        checkOutput("rise_pulse_end", 32'(rise_o),           32'd0);
        checkOutput("rise_cnt1",      32'(rise_cnt),         32'd1);
        checkOutput("evt_valid1",     32'(evt_if.evt_valid), 32'd1);
        checkOutput("evt_type1",      32'(evt_if.evt_type),  32'd1);
        checkOutput("evt_time1",      32'(evt_if.evt_time),  32'(exp_time));

        // Fall while the rise event is still unread: dropped, overflow set
        saw_fall = 1'b0;
        applyStimulus(1'b0, 10);
        checkOutput("fall_seen",    32'(saw_fall),         32'd1);
        checkOutput("fall_cnt1",    32'(fall_cnt),         32'd1);
        checkOutput("hold_valid",   32'(evt_if.evt_valid), 32'd1);
        checkOutput("hold_type",    32'(evt_if.evt_type),  32'd1);
        checkOutput("ovf_set",      32'(evt_if.evt_ovf),   32'd1);
        evt_if.evt_ready = 1'b1;
        tick();
        evt_if.evt_ready = 1'b0;
        checkOutput("hs_valid",     32'(evt_if.evt_valid), 32'd0);
        checkOutput("ovf_sticky",   32'(evt_if.evt_ovf),   32'd1);

        // Two-cycle glitch is rejected with filt_len=3
        saw_rise = 1'b0;
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 10);
        checkOutput("glitch_level", 32'(level_o),  32'd0);
        checkOutput("glitch_pulse", 32'(saw_rise), 32'd0);
        checkOutput("glitch_cnt",   32'(rise_cnt), 32'd1);

        // Disabled: level tracks samp without pulses, counts or events
        enable = 1'b0; saw_rise = 1'b0; saw_fall = 1'b0;
        applyStimulus(1'b1, 5);
        checkOutput("dis_level_hi", 32'(level_o),          32'd1);
        checkOutput("dis_no_rise",  32'(saw_rise),         32'd0);
        checkOutput("dis_rise_cnt", 32'(rise_cnt),         32'd1);
        checkOutput("dis_no_evt",   32'(evt_if.evt_valid), 32'd0);
        applyStimulus(1'b0, 5);
        checkOutput("dis_level_lo", 32'(level_o),  32'd0);
        checkOutput("dis_no_fall",  32'(saw_fall), 32'd0);
        checkOutput("dis_fall_cnt", 32'(fall_cnt), 32'd1);
        enable = 1'b1;
        repeat (2) tick();

        // Clear landing on the same edge as an accepted fall
        applyStimulus(1'b1, 10);
        checkOutput("pre_clr_rise_cnt", 32'(rise_cnt),         32'd2);
        checkOutput("pre_clr_valid",    32'(evt_if.evt_valid), 32'd1);
        comp_in = 1'b0;
        repeat (6) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("clr_level",    32'(level_o),          32'd0);
        checkOutput("clr_fall_o",   32'(fall_o),           32'd1);
        checkOutput("clr_fall_cnt", 32'(fall_cnt),         32'd0);
        checkOutput("clr_rise_cnt", 32'(rise_cnt),         32'd0);
        checkOutput("clr_valid",    32'(evt_if.evt_valid), 32'd0);
        checkOutput("clr_ovf",      32'(evt_if.evt_ovf),   32'd0);

        // filt_len=0 accepts one cycle after pending entry
        filt_len = 8'd0;
        comp_in = 1'b1;
        repeat (3) tick();
        checkOutput("f0_pending", 32'(level_o), 32'd0);
        tick();
        checkOutput("f0_level",   32'(level_o),  32'd1);
        checkOutput("f0_pulse",   32'(rise_o),   32'd1);
        checkOutput("f0_cnt",     32'(rise_cnt), 32'd1);
        repeat (2) tick();

        // filt_len change while pending is ignored
        filt_len = 8'd1;
        comp_in = 1'b0;
        repeat (3) tick();
        filt_len = 8'd5;
        tick();
        checkOutput("latch_hold",  32'(level_o),        32'd1);
        tick();
        checkOutput("latch_level", 32'(level_o),        32'd0);
        checkOutput("latch_pulse", 32'(fall_o),         32'd1);
        checkOutput("latch_drop",  32'(evt_if.evt_ovf), 32'd1);

        // Saturation: 20 rises/falls, the 4-bit instance sticks at 15
        evt_if.evt_ready = 1'b1;
        filt_len = 8'd0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("sat_clr4", 32'(rise_cnt4), 32'd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 5);
            applyStimulus(1'b0, 5);
        end
        checkOutput("sat_rise16", 32'(rise_cnt),       32'd20);
        checkOutput("sat_fall16", 32'(fall_cnt),       32'd20);
        checkOutput("sat_rise4",  32'(rise_cnt4),      32'd15);
        checkOutput("sat_fall4",  32'(fall_cnt4),      32'd15);
        checkOutput("sat_no_ovf", 32'(evt_if.evt_ovf), 32'd0);

        // Reset in the middle of a pending rise
        evt_if.evt_ready = 1'b0;
        filt_len = 8'd3;
        comp_in = 1'b1;
        repeat (4) tick();
        resetb = 1'b0;
        #1;
        checkOutput("mrst_level",  32'(level_o),          32'd0);
        checkOutput("mrst_rise_o", 32'(rise_o),           32'd0);
        checkOutput("mrst_rcnt",   32'(rise_cnt),         32'd0);
        checkOutput("mrst_fcnt4",  32'(fall_cnt4),        32'd0);
        checkOutput("mrst_valid",  32'(evt_if.evt_valid), 32'd0);
        checkOutput("mrst_type",   32'(evt_if.evt_type),  32'd0);
        @(posedge clock);
        #1;
        resetb = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) checkOutput("post_rst_early", 32'(level_o), 32'd0);
            if (k == 7) begin
                checkOutput("post_rst_level", 32'(level_o), 32'd1);
                checkOutput("post_rst_pulse", 32'(rise_o),  32'd1);
            end
        end
        checkOutput("post_rst_cnt", 32'(rise_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
